instruction_fetch_unit: RTL and testbench

Fetch-side initiator for the single-cycle-read instruction memory. Holds the program counter, drives a word address to the memory every cycle, captures the returned word with its PC into a small prefetch FIFO, and hands instructions to decode over a valid/ready handshake. A redirect input, used for branches, jumps and traps, flushes buffered instructions and restarts fetch at a new PC.

---
 rtl/instruction_fetch_unit.sv | 73 +++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, prefetch FIFO and decode handshake for single-cycle imem
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_dout,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst,
    output logic [31:0]                   inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int            AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   word_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign pop  = inst_valid & inst_ready;
    // A full FIFO may still accept a fetch when decode frees the head this cycle
    assign push = ~redirect_valid & ((count != DEPTH) | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc;
            word_mem[wr_ptr] <= imem_dout;
        end
    end

    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? word_mem[rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'd0;
    assign fifo_count = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - vector table, directed corners and queue-model random check
module tb_instruction_fetch_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_dout;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic [2:0]  fifo_count;

    logic        reset_w = 1'b0;
    logic [31:0] imem_addr_w, imem_dout_w;
    logic        inst_valid_w;
    logic [31:0] inst_w, inst_pc_w;
    logic [2:0]  fifo_count_w;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_dout   = memw(imem_addr);
    assign imem_dout_w = memw(imem_addr_w);

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .fifo_count(fifo_count));

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(D)) dut_w (
        .clk(clk), .reset(reset_w), .imem_addr(imem_addr_w), .imem_dout(imem_dout_w),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .inst_valid(inst_valid_w), .inst_ready(1'b1), .inst(inst_w),
        .inst_pc(inst_pc_w), .fifo_count(fifo_count_w));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input int ecnt, input logic [31:0] eaddr, input logic [31:0] einst);
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, ev});
        chk({tag, ".inst_pc"}, inst_pc, epc);
        chk({tag, ".inst"}, inst, einst);
        chk({tag, ".count"}, 32'(fifo_count), ecnt);
        chk({tag, ".addr"}, imem_addr, eaddr);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        int          ecnt;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    vec_t        tbl [29];
    ent_t        q [$];
    logic [31:0] mpc;
    logic [31:0] wrap_pcs [4];

    initial begin
        tbl[0]  = '{1, 1, 0, 32'h0,   1, 32'h0,   1, 32'h4};
        tbl[1]  = '{0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h8};
        tbl[2]  = '{0, 1, 0, 32'h0,   1, 32'h8,   1, 32'hC};
        tbl[3]  = '{0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h10};
        tbl[4]  = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h4};
        tbl[5]  = '{0, 0, 0, 32'h0,   1, 32'h0,   2, 32'h8};
        tbl[6]  = '{0, 0, 0, 32'h0,   1, 32'h0,   3, 32'hC};
        tbl[7]  = '{0, 0, 0, 32'h0,   1, 32'h0,   4, 32'h10};
        for (int i = 8; i < 14; i++)
            tbl[i] = '{0, 0, 0, 32'h0, 1, 32'h0, 4, 32'h10};
        tbl[14] = '{0, 1, 0, 32'h0,   1, 32'h4,   4, 32'h14};
        tbl[15] = '{0, 1, 0, 32'h0,   1, 32'h8,   4, 32'h18};
        tbl[16] = '{0, 1, 0, 32'h0,   1, 32'hC,   4, 32'h1C};
        tbl[17] = '{0, 1, 0, 32'h0,   1, 32'h10,  4, 32'h20};
        tbl[18] = '{0, 1, 0, 32'h0,   1, 32'h14,  4, 32'h24};
        tbl[19] = '{0, 0, 1, 32'h203, 0, 32'h0,   0, 32'h200};
        tbl[20] = '{0, 1, 0, 32'h0,   1, 32'h200, 1, 32'h204};
        tbl[21] = '{0, 1, 0, 32'h0,   1, 32'h204, 1, 32'h208};
        tbl[22] = '{0, 1, 1, 32'h100, 0, 32'h0,   0, 32'h100};
        tbl[23] = '{0, 1, 0, 32'h0,   1, 32'h100, 1, 32'h104};
        tbl[24] = '{0, 1, 1, 32'h40,  0, 32'h0,   0, 32'h40};
        tbl[25] = '{0, 1, 1, 32'h80,  0, 32'h0,   0, 32'h80};
        tbl[26] = '{0, 1, 0, 32'h0,   1, 32'h80,  1, 32'h84};
        tbl[27] = '{0, 0, 0, 32'h0,   1, 32'h80,  2, 32'h88};
        tbl[28] = '{0, 0, 0, 32'h0,   1, 32'h80,  3, 32'h8C};

        #1;
        chk_all("reset", 1'b0, 32'h0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 29; i++) begin
            if (tbl[i].rst) pulse_reset();
            inst_ready     = tbl[i].ready;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ecnt,
                    tbl[i].eaddr, tbl[i].ev ? memw(tbl[i].epc) : 32'h0);
        end

        // Asynchronous reset with three entries buffered, between clock edges
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk_all("async_rst", 1'b0, 32'h0, 0, 32'h0, 32'h0);
        #3 reset = 1'b1;
        @(negedge clk);
        chk_all("after_async", 1'b0, 32'h0, 0, 32'h0, 32'h0);
        inst_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all("restart", 1'b1, 32'h0, 1, 32'h4, memw(32'h0));

        // PC wrap-around on the second instance
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;
        wrap_pcs[3] = 32'h0000_0004;
        chk("wrap.addr_rst", imem_addr_w, 32'hFFFF_FFF8);
        reset_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("wrap%0d.pc", i), inst_pc_w, wrap_pcs[i]);
            chk($sformatf("wrap%0d.inst", i), inst_w, memw(wrap_pcs[i]));
            chk($sformatf("wrap%0d.valid", i), {31'd0, inst_valid_w}, 32'd1);
            chk($sformatf("wrap%0d.count", i), 32'(fifo_count_w), 32'd1);
        end

        // Random traffic against a queue reference model
        pulse_reset();
        q.delete();
        mpc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            logic pop_m;
            logic full_m;
            inst_ready     = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = $urandom;
            @(posedge clk);
            if (redirect_valid) begin
                q.delete();
                mpc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                full_m = (q.size() == D);
                pop_m  = (q.size() != 0) && inst_ready;
                if (pop_m) void'(q.pop_front());
                if (!full_m || pop_m) begin
                    q.push_back('{mpc, memw(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
            @(negedge clk);
            if (q.size() != 0)
                chk_all($sformatf("rnd%0d", c), 1'b1, q[0].pc, q.size(), mpc, q[0].w);
            else
                chk_all($sformatf("rnd%0d", c), 1'b0, 32'h0, 0, mpc, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
